// File: rtl/gerenciador_senha_if.sv
// Bus between the safe and the password-programming controller.
// The master drives the keypad/FSM side; the slave is the controller itself.
interface gerenciador_senha_if;
    logic        desbloqueado;
    logic        prog;
    logic        confirma;
    logic [3:0]  digito;
    logic [15:0] senha;
    logic [15:0] entrada;
    logic        ativo;
    logic        fase;
    logic [1:0]  indice;
    logic        ok;
    logic        falha;

    modport master (
        output desbloqueado, prog, confirma, digito,
        input  senha, entrada, ativo, fase, indice, ok, falha
    );

    modport slave (
        input  desbloqueado, prog, confirma, digito,
        output senha, entrada, ativo, fase, indice, ok, falha
    );
endinterface

// File: rtl/gerenciador_senha.sv
// Password-programming controller: new entry, confirmation entry, then commit
// on match. Every output is driven straight from a register.
module gerenciador_senha #(
    parameter logic [15:0] SENHA_PADRAO = 16'h3015,
    parameter logic [28:0] TIMEOUT      = 29'd500_000_000
) (
    input  logic               MAX10_CLK1_50,
    input  logic               reset,
    gerenciador_senha_if.slave io_bus
);

    typedef enum logic [1:0] {OCIOSO, NOVO, CONFIRMA, VERIFICA} estado_t;

    estado_t     r_estado, w_estadoProx;
    logic [15:0] r_novo, w_novoProx;
    logic [15:0] r_conf, w_confProx;
    logic [15:0] r_senha, w_senhaProx;
    logic [15:0] r_entrada, w_entradaProx;
    logic [1:0]  r_indice, w_indiceProx;
    logic [28:0] r_timer, w_timerProx;
    logic        r_fase, w_faseProx;
    logic        r_ok, w_okProx;
    logic        r_falha, w_falhaProx;
    logic        r_ativo;
    logic        w_digitoValido;

    // Digit 1 lives in the top nibble, so index 0 maps to bits [15:12].
    function automatic logic [15:0] inserirDigito(input logic [15:0] valor,
                                                  input logic [1:0]  idx,
                                                  input logic [3:0]  d);
        logic [15:0] res;
        res = valor;
        case (idx)
            2'd0:    res[15:12] = d;
            2'd1:    res[11:8]  = d;
            2'd2:    res[7:4]   = d;
            default: res[3:0]   = d;
        endcase
        return res;
    endfunction

    assign w_digitoValido = io_bus.confirma && (io_bus.digito <= 4'd9);

    always_comb begin
        w_estadoProx = r_estado;
        w_novoProx   = r_novo;
        w_confProx   = r_conf;
        w_senhaProx  = r_senha;
        w_indiceProx = r_indice;
        w_timerProx  = r_timer;
        w_faseProx   = r_fase;
        w_okProx     = 1'b0;
        w_falhaProx  = 1'b0;

        case (r_estado)
            OCIOSO: begin
                if (io_bus.prog && io_bus.desbloqueado) begin
                    w_estadoProx = NOVO;
                end
            end
            NOVO, CONFIRMA: begin
                if (!io_bus.desbloqueado) begin
                    w_estadoProx = OCIOSO;
                    w_falhaProx  = 1'b1;
                end else if (r_timer == TIMEOUT - 29'd1) begin
                    w_estadoProx = OCIOSO;
                    w_falhaProx  = 1'b1;
                end else if (w_digitoValido) begin
                    if (r_estado == NOVO) begin
                        w_novoProx = inserirDigito(r_novo, r_indice, io_bus.digito);
                    end else begin
                        w_confProx = inserirDigito(r_conf, r_indice, io_bus.digito);
                    end
                    w_indiceProx = r_indice + 2'd1;
                    w_timerProx  = '0;
                    if (r_indice == 2'd3) begin
                        if (r_estado == NOVO) begin
                            w_estadoProx = CONFIRMA;
                            w_faseProx   = 1'b1;
                        end else begin
                            w_estadoProx = VERIFICA;
                        end
                    end
                end else begin
                    w_timerProx = r_timer + 29'd1;
                end
            end
            default: begin
                w_estadoProx = OCIOSO;
                if (r_novo == r_conf) begin
                    w_senhaProx = r_novo;
                    w_okProx    = 1'b1;
                end else begin
                    w_falhaProx = 1'b1;
                end
            end
        endcase

        // Entering or staying idle always wipes the entry context.
        if (w_estadoProx == OCIOSO) begin
            w_novoProx   = 16'hFFFF;
            w_confProx   = 16'hFFFF;
            w_indiceProx = 2'd0;
            w_faseProx   = 1'b0;
            w_timerProx  = '0;
        end

        w_entradaProx = w_faseProx ? w_confProx : w_novoProx;
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            r_estado  <= OCIOSO;
            r_novo    <= 16'hFFFF;
            r_conf    <= 16'hFFFF;
            r_senha   <= SENHA_PADRAO;
            r_entrada <= 16'hFFFF;
            r_indice  <= 2'd0;
            r_timer   <= '0;
            r_fase    <= 1'b0;
            r_ok      <= 1'b0;
            r_falha   <= 1'b0;
            r_ativo   <= 1'b0;
        end else begin
            r_estado  <= w_estadoProx;
            r_novo    <= w_novoProx;
            r_conf    <= w_confProx;
            r_senha   <= w_senhaProx;
            r_entrada <= w_entradaProx;
            r_indice  <= w_indiceProx;
            r_timer   <= w_timerProx;
            r_fase    <= w_faseProx;
            r_ok      <= w_okProx;
            r_falha   <= w_falhaProx;
            r_ativo   <= (w_estadoProx != OCIOSO);
        end
    end

    assign io_bus.senha   = r_senha;
    assign io_bus.entrada = r_entrada;
    assign io_bus.ativo   = r_ativo;
    assign io_bus.fase    = r_fase;
    assign io_bus.indice  = r_indice;
    assign io_bus.ok      = r_ok;
    assign io_bus.falha   = r_falha;

endmodule

// File: tb/tb_gerenciador_senha.sv
// Directed bench for gerenciador_senha with TIMEOUT shortened to 100 cycles.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
module tb_gerenciador_senha;

    logic clk;
    logic reset;
    int   numAsserts;
    int   numFails;

    gerenciador_senha_if bus();

    gerenciador_senha #(
        .SENHA_PADRAO (16'h3015),
        .TIMEOUT      (29'd100)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .reset         (reset),
        .io_bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic p, input logic c, input logic [3:0] d);
        bus.prog     = p;
        bus.confirma = c;
        bus.digito   = d;
        @(posedge clk);
        #1;
        bus.prog     = 1'b0;
        bus.confirma = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numAsserts++;
        assert (observed === expected) else begin
            numFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic enterDigits(input logic [15:0] digs);
        applyStimulus(1'b0, 1'b1, digs[15:12]);
        applyStimulus(1'b0, 1'b1, digs[11:8]);
        applyStimulus(1'b0, 1'b1, digs[7:4]);
        applyStimulus(1'b0, 1'b1, digs[3:0]);
    endtask

    task automatic doReset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        numAsserts       = 0;
        numFails         = 0;
        bus.desbloqueado = 1'b0;
        bus.prog         = 1'b0;
        bus.confirma     = 1'b0;
        bus.digito       = 4'd0;
        reset            = 1'b1;
        @(posedge clk);
        #1;
        doReset();
        idle(10);
        checkOutput("reset senha",   bus.senha,   32'h3015);
        checkOutput("reset entrada", bus.entrada, 32'hFFFF);
        checkOutput("reset ativo",   bus.ativo,   32'h0);
        checkOutput("reset fase",    bus.fase,    32'h0);
        checkOutput("reset indice",  bus.indice,  32'h0);
        checkOutput("reset ok",      bus.ok,      32'h0);
        checkOutput("reset falha",   bus.falha,   32'h0);

        // Successful programming 7294 / 7294
        bus.desbloqueado = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'd0);
        checkOutput("prog ativo", bus.ativo, 32'h1);
        applyStimulus(1'b0, 1'b1, 4'd7);
        checkOutput("novo d1 entrada", bus.entrada, 32'h7FFF);
        checkOutput("novo d1 indice",  bus.indice,  32'h1);
        applyStimulus(1'b0, 1'b1, 4'd2);
        applyStimulus(1'b0, 1'b1, 4'd9);
        applyStimulus(1'b0, 1'b1, 4'd4);
        checkOutput("to confirma fase",    bus.fase,    32'h1);
        checkOutput("to confirma indice",  bus.indice,  32'h0);
        checkOutput("to confirma entrada", bus.entrada, 32'hFFFF);
        applyStimulus(1'b0, 1'b1, 4'd7);
        applyStimulus(1'b0, 1'b1, 4'd2);
        applyStimulus(1'b0, 1'b1, 4'd9);
        checkOutput("conf d3 entrada", bus.entrada, 32'h729F);
        applyStimulus(1'b0, 1'b1, 4'd4);
        checkOutput("verifica ok early", bus.ok,    32'h0);
        checkOutput("verifica ativo",    bus.ativo, 32'h1);
        idle(1);
        checkOutput("match ok",      bus.ok,      32'h1);
        checkOutput("match falha",   bus.falha,   32'h0);
        checkOutput("match senha",   bus.senha,   32'h7294);
        checkOutput("match ativo",   bus.ativo,   32'h0);
        checkOutput("match entrada", bus.entrada, 32'hFFFF);
        idle(1);
        checkOutput("match ok pulse", bus.ok, 32'h0);

        // Mismatch 7294 / 7295 after reset
        doReset();
        applyStimulus(1'b1, 1'b0, 4'd0);
        enterDigits(16'h7294);
        enterDigits(16'h7295);
        idle(1);
        checkOutput("mismatch falha", bus.falha, 32'h1);
        checkOutput("mismatch ok",    bus.ok,    32'h0);
        checkOutput("mismatch senha", bus.senha, 32'h3015);
        idle(1);
        checkOutput("mismatch falha pulse", bus.falha, 32'h0);

        // prog beats confirma in OCIOSO; invalid digit ignored; then valid digit
        applyStimulus(1'b1, 1'b1, 4'd5);
        checkOutput("prog+conf ativo",   bus.ativo,   32'h1);
        checkOutput("prog+conf indice",  bus.indice,  32'h0);
        checkOutput("prog+conf entrada", bus.entrada, 32'hFFFF);
        applyStimulus(1'b0, 1'b1, 4'd12);
        checkOutput("invalid indice",  bus.indice,  32'h0);
        checkOutput("invalid entrada", bus.entrada, 32'hFFFF);
        applyStimulus(1'b0, 1'b1, 4'd1);
        checkOutput("valid entrada", bus.entrada, 32'h1FFF);
        checkOutput("valid indice",  bus.indice,  32'h1);

        // Timeout 100 cycles after the capture; invalid confirma must not reset it
        idle(50);
        applyStimulus(1'b0, 1'b1, 4'd13);
        idle(48);
        checkOutput("timeout early falha", bus.falha, 32'h0);
        checkOutput("timeout early ativo", bus.ativo, 32'h1);
        idle(1);
        checkOutput("timeout falha",   bus.falha,   32'h1);
        checkOutput("timeout ativo",   bus.ativo,   32'h0);
        checkOutput("timeout entrada", bus.entrada, 32'hFFFF);

        // Commit 5555, then abort during confirmation
        idle(1);
        applyStimulus(1'b1, 1'b0, 4'd0);
        enterDigits(16'h5555);
        enterDigits(16'h5555);
        idle(1);
        checkOutput("commit5555 senha", bus.senha, 32'h5555);
        applyStimulus(1'b1, 1'b0, 4'd0);
        enterDigits(16'h1234);
        applyStimulus(1'b0, 1'b1, 4'd5);
        checkOutput("conf d1 entrada", bus.entrada, 32'h5FFF);
        bus.desbloqueado = 1'b0;
        applyStimulus(1'b0, 1'b1, 4'd6);
        checkOutput("abort falha",   bus.falha,   32'h1);
        checkOutput("abort ativo",   bus.ativo,   32'h0);
        checkOutput("abort indice",  bus.indice,  32'h0);
        checkOutput("abort entrada", bus.entrada, 32'hFFFF);
        checkOutput("abort senha",   bus.senha,   32'h5555);
        applyStimulus(1'b1, 1'b0, 4'd0);
        checkOutput("locked prog ativo", bus.ativo, 32'h0);
        checkOutput("abort falha pulse", bus.falha, 32'h0);

        // Reset mid-NOVO restores every output
        bus.desbloqueado = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 4'd8);
        checkOutput("mid novo entrada", bus.entrada, 32'h8FFF);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        checkOutput("midreset senha",   bus.senha,   32'h3015);
        checkOutput("midreset entrada", bus.entrada, 32'hFFFF);
        checkOutput("midreset ativo",   bus.ativo,   32'h0);
        checkOutput("midreset fase",    bus.fase,    32'h0);
        checkOutput("midreset indice",  bus.indice,  32'h0);
        checkOutput("midreset ok",      bus.ok,      32'h0);
        checkOutput("midreset falha",   bus.falha,   32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
        $finish;
    end

endmodule
